// File: rtl/ov_dvp_tx.sv
// OV-style DVP camera transmitter: emits VSYNC/HREF/byte timing of an
// 8-bit parallel camera interface from an RGB565 stream or internal bars.
module ov_dvp_tx #(
    parameter int H_ACTIVE    = 640,
    parameter int H_BLANK     = 144,
    parameter int V_ACTIVE    = 480,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        pattern_en,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        cam_PCLK,
    output logic        cam_VSYNC,
    output logic        cam_HREF,
    output logic [7:0]  cam_data,
    output logic        frame_start,
    output logic        underflow
);

    localparam int LINE_SLOTS = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W      = $clog2(LINE_SLOTS + 1);
    localparam int LINE_W     = $clog2(VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);
    localparam int BAR_W      = H_ACTIVE / 8;
    localparam int BAR_DIV    = (BAR_W > 0) ? BAR_W : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_SLOTS - 1);
    localparam logic [COL_W-1:0] ACT_SLOTS = COL_W'(2 * H_ACTIVE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_t;

    state_t            state, state_n;
    logic [COL_W-1:0]  col, col_n;
    logic [LINE_W-1:0] line, line_n;
    logic              pattern_mode;
    logic [7:0]        low_byte;
    logic              next_href;
    logic              next_byte0;
    logic              vsync_rise;
    logic [15:0]       next_pixel;

    // Index of the last line spent in each vertical region.
    function automatic logic [LINE_W-1:0] last_line(input state_t s);
        case (s)
            ST_VSYNC:  last_line = LINE_W'(VSYNC_LINES - 1);
            ST_VBACK:  last_line = LINE_W'(V_BACK - 1);
            ST_ACTIVE: last_line = LINE_W'(V_ACTIVE - 1);
            ST_VFRONT: last_line = LINE_W'(V_FRONT - 1);
            default:   last_line = '0;
        endcase
    endfunction

    // Eight full-scale colour bars; columns past the last whole bar are black.
    function automatic logic [15:0] bar_colour(input logic [COL_W-1:0] pix);
        int idx;
        idx = (BAR_W == 0) ? 8 : int'(pix) / BAR_DIV;
        case (idx)
            0:       bar_colour = 16'hFFFF; // white
            1:       bar_colour = 16'hFFE0; // yellow
            2:       bar_colour = 16'h07FF; // cyan
            3:       bar_colour = 16'h07E0; // green
            4:       bar_colour = 16'hF81F; // magenta
            5:       bar_colour = 16'hF800; // red
            6:       bar_colour = 16'h001F; // blue
            default: bar_colour = 16'h0000; // black
        endcase
    endfunction

    // Position and attributes of the byte slot that starts at the next PCLK fall.
    always_comb begin
        state_n = state;
        col_n   = col;
        line_n  = line;
        if (state == ST_IDLE) begin
            if (enable) state_n = ST_VSYNC;
        end else if (col == COL_LAST) begin
            col_n = '0;
            if (line == last_line(state)) begin
                line_n = '0;
                case (state)
                    ST_VSYNC:  state_n = ST_VBACK;
                    ST_VBACK:  state_n = ST_ACTIVE;
                    ST_ACTIVE: state_n = ST_VFRONT;
                    ST_VFRONT: state_n = enable ? ST_VSYNC : ST_IDLE;
                    default:   state_n = ST_IDLE;
                endcase
            end else begin
                line_n = line + 1'b1;
            end
        end else begin
            col_n = col + 1'b1;
        end
        next_href  = (state_n == ST_ACTIVE) && (col_n < ACT_SLOTS);
        next_byte0 = next_href && !col_n[0];
        vsync_rise = (state_n == ST_VSYNC) && (state != ST_VSYNC);
        pix_ready  = cam_PCLK && next_byte0 && !pattern_mode;
        if (pattern_mode)   next_pixel = bar_colour(col_n >> 1);
        else if (pix_valid) next_pixel = pix_data;
        else                next_pixel = 16'h0000;
    end

    // Timing state and bus outputs; everything advances only at a slot start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            col          <= '0;
            line         <= '0;
            cam_PCLK     <= 1'b0;
            cam_VSYNC    <= 1'b0;
            cam_HREF     <= 1'b0;
            cam_data     <= 8'h00;
            frame_start  <= 1'b0;
            underflow    <= 1'b0;
            pattern_mode <= 1'b0;
        end else begin
            cam_PCLK    <= ~cam_PCLK;
            frame_start <= cam_PCLK && vsync_rise;
            if (cam_PCLK) begin
                state     <= state_n;
                col       <= col_n;
                line      <= line_n;
                cam_VSYNC <= (state_n == ST_VSYNC);
                cam_HREF  <= next_href;
                if (next_byte0)     cam_data <= next_pixel[15:8];
                else if (next_href) cam_data <= low_byte;
                else                cam_data <= 8'h00;
                if (vsync_rise) pattern_mode <= pattern_en;
                if (pix_ready && !pix_valid) underflow <= 1'b1;
            end
        end
    end

    // Low byte of the current pixel, held for the second slot of the pair.
    always_ff @(posedge clk) begin
        if (cam_PCLK && next_byte0) low_byte <= next_pixel[7:0];
    end

endmodule

// File: tb/tb_ov_dvp_tx.sv
// Bench for ov_dvp_tx: directed stream/pattern/enable/reset sequences plus a
// randomized run compared cycle-by-cycle against a flat slot-index model.
module tb_ov_dvp_tx;

    localparam int HA = 4, HB = 2, VA = 2, VS = 1, VB = 1, VF = 1;
    localparam int L  = 2 * HA + HB;
    localparam int F  = (VS + VB + VA + VF) * L;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    typedef struct {
        logic [15:0] pix;
        logic        valid;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
    } pat_t;

    logic        clk = 1'b0;
    logic        rst, enable, pattern_en, pix_valid, en_b;
    logic [15:0] pix_data;
    logic        a_ready, a_pclk, a_vsync, a_href, a_fs, a_uf;
    logic [7:0]  a_data;
    logic        b_ready, b_pclk, b_vsync, b_href, b_fs, b_uf;
    logic [7:0]  b_data;

    int checks = 0, failures = 0, cyc = 0;
    int vs_cnt, hr_cnt, rdy_cnt, rdy_b, fs_cnt, valid_pct;
    logic [7:0] qa[$], qb[$];
    vec_t feed[$];
    vec_t tab1[4], tab2[4];
    pat_t tabp[8];

    // model state
    logic m_pclk = 0, m_run = 0, m_mode = 0, m_uf = 0, m_vs = 0, m_href = 0;
    logic m_fs = 0, m_ready = 0;
    logic [7:0] m_data = 0, m_lo = 0;
    int m_slot = 0;

    ov_dvp_tx #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .VSYNC_LINES(VS),
                .V_BACK(VB), .V_FRONT(VF)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .pattern_en(pattern_en),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(a_ready),
        .cam_PCLK(a_pclk), .cam_VSYNC(a_vsync), .cam_HREF(a_href),
        .cam_data(a_data), .frame_start(a_fs), .underflow(a_uf));

    ov_dvp_tx #(.H_ACTIVE(8), .H_BLANK(2), .V_ACTIVE(2), .VSYNC_LINES(1),
                .V_BACK(1), .V_FRONT(1)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .pattern_en(1'b1),
        .pix_data(16'h0000), .pix_valid(1'b0), .pix_ready(b_ready),
        .cam_PCLK(b_pclk), .cam_VSYNC(b_vsync), .cam_HREF(b_href),
        .cam_data(b_data), .frame_start(b_fs), .underflow(b_uf));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] bar(input int p);
        int w = HA / 8;
        if (w == 0 || p / w > 7) return 16'h0000;
        return BARS[p / w];
    endfunction

    function automatic logic slot_is_byte0(input int s);
        int ln = s / L, cl = s % L;
        return (ln >= VS + VB) && (ln < VS + VB + VA) && (cl < 2 * HA) && (cl % 2 == 0);
    endfunction

    // Advance the model by one clk using the inputs about to be sampled.
    task automatic model_step();
        logic fs = 0;
        int ln, cl;
        logic [15:0] px;
        if (rst) begin
            m_pclk = 0; m_run = 0; m_slot = 0; m_mode = 0; m_uf = 0;
            m_vs = 0; m_href = 0; m_data = 0;
        end else begin
            if (m_pclk) begin
                if (m_run) begin
                    if (m_slot == F - 1) begin
                        if (enable) begin m_slot = 0; fs = 1; end
                        else m_run = 0;
                    end else m_slot++;
                end else if (enable) begin
                    m_run = 1; m_slot = 0; fs = 1;
                end
                if (fs) m_mode = pattern_en;
                ln = m_slot / L; cl = m_slot % L;
                m_vs   = m_run && (ln < VS);
                m_href = m_run && (ln >= VS + VB) && (ln < VS + VB + VA) && (cl < 2 * HA);
                if (m_href && cl % 2 == 0) begin
                    if (m_mode) px = bar(cl / 2);
                    else if (pix_valid) px = pix_data;
                    else begin px = 16'h0000; m_uf = 1; end
                    m_data = px[15:8]; m_lo = px[7:0];
                end else if (m_href) m_data = m_lo;
                else m_data = 8'h00;
            end
            m_pclk = ~m_pclk;
        end
        m_fs = fs;
        m_ready = m_pclk && !m_mode && m_run && (m_slot + 1 < F) && slot_is_byte0(m_slot + 1);
    endtask

    // Compare DUT A to the model mid-cycle, then step the model.
    always @(negedge clk) begin
        chk("m_pclk",  32'(a_pclk),  32'(m_pclk));
        chk("m_vsync", 32'(a_vsync), 32'(m_vs));
        chk("m_href",  32'(a_href),  32'(m_href));
        chk("m_data",  32'(a_data),  32'(m_data));
        chk("m_fs",    32'(a_fs),    32'(m_fs));
        chk("m_uf",    32'(a_uf),    32'(m_uf));
        chk("m_ready", 32'(a_ready), 32'(m_ready));
        model_step();
    end

    task automatic cycle();
        vec_t v;
        @(posedge clk); #1;
        cyc++;
        if (a_href && !a_pclk) qa.push_back(a_data);
        if (b_href && !b_pclk) qb.push_back(b_data);
        if (a_vsync) vs_cnt++;
        if (a_href) hr_cnt++;
        if (a_ready) rdy_cnt++;
        if (b_ready) rdy_b++;
        if (a_fs) fs_cnt++;
        if (a_ready && feed.size() > 0) begin
            v = feed.pop_front();
            pix_data = v.pix; pix_valid = v.valid;
        end else begin
            pix_data = 16'($urandom);
            pix_valid = ($urandom_range(0, 99) < valid_pct);
        end
    endtask

    task automatic wait_fs(input int limit, output int n);
        n = 0;
        do begin cycle(); n++; end while (!a_fs && n < limit);
    endtask

    function automatic logic [7:0] qa_at(input int i);
        return (i < qa.size()) ? qa[i] : 8'hxx;
    endfunction

    function automatic logic [7:0] qb_at(input int i);
        return (i < qb.size()) ? qb[i] : 8'hxx;
    endfunction

    task automatic clear_counts();
        vs_cnt = 0; hr_cnt = 0; rdy_cnt = 0; fs_cnt = 0; qa.delete();
    endtask

    initial begin
        int n;
        tab1[0] = '{16'hF800, 1'b1, 8'hF8, 8'h00};
        tab1[1] = '{16'h07E0, 1'b1, 8'h07, 8'hE0};
        tab1[2] = '{16'h001F, 1'b1, 8'h00, 8'h1F};
        tab1[3] = '{16'hFFFF, 1'b1, 8'hFF, 8'hFF};
        tab2[0] = '{16'hF800, 1'b1, 8'hF8, 8'h00};
        tab2[1] = '{16'h07E0, 1'b0, 8'h00, 8'h00};
        tab2[2] = '{16'h001F, 1'b1, 8'h00, 8'h1F};
        tab2[3] = '{16'hFFFF, 1'b1, 8'hFF, 8'hFF};
        tabp[0] = '{8'hFF, 8'hFF}; tabp[1] = '{8'hFF, 8'hE0};
        tabp[2] = '{8'h07, 8'hFF}; tabp[3] = '{8'h07, 8'hE0};
        tabp[4] = '{8'hF8, 8'h1F}; tabp[5] = '{8'hF8, 8'h00};
        tabp[6] = '{8'h00, 8'h1F}; tabp[7] = '{8'h00, 8'h00};

        rst = 1; enable = 0; en_b = 0; pattern_en = 0;
        pix_data = 0; pix_valid = 1; valid_pct = 100; rdy_b = 0;
        clear_counts();
        repeat (3) cycle();
        chk("rst_pclk",  32'(a_pclk), 0);
        chk("rst_vsync", 32'(a_vsync), 0);
        chk("rst_href",  32'(a_href), 0);
        chk("rst_data",  32'(a_data), 0);
        chk("rst_ready", 32'(a_ready), 0);
        chk("rst_fs",    32'(a_fs), 0);
        chk("rst_uf",    32'(a_uf), 0);
        chk("rst_b_out", 32'({b_pclk, b_vsync, b_href, b_data, b_fs, b_uf}), 0);

        // Stream frame with four known pixels per line.
        rst = 0; enable = 1; en_b = 1;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 4; j++) feed.push_back(tab1[j]);
        wait_fs(10, n);
        chk("fs_after_release_le2", 32'(n <= 2), 1);
        chk("vsync_with_fs", 32'(a_vsync), 1);
        clear_counts();
        wait_fs(200, n);
        chk("frame_period", n, 100);
        chk("vsync_clks", vs_cnt, 20);
        chk("href_clks", hr_cnt, 32);
        chk("ready_pulses", rdy_cnt, 8);
        chk("byte_count", qa.size(), 16);
        for (int i = 0; i < 8; i++) begin
            chk("stream_b0", 32'(qa_at(2 * i)), 32'(tab1[i % 4].b0));
            chk("stream_b1", 32'(qa_at(2 * i + 1)), 32'(tab1[i % 4].b1));
        end
        chk("underflow_clear", 32'(a_uf), 0);

        // Second pixel of the line missing.
        for (int j = 0; j < 4; j++) feed.push_back(tab2[j]);
        clear_counts();
        wait_fs(200, n);
        chk("frame_period2", n, 100);
        for (int i = 0; i < 4; i++) begin
            chk("uf_b0", 32'(qa_at(2 * i)), 32'(tab2[i].b0));
            chk("uf_b1", 32'(qa_at(2 * i + 1)), 32'(tab2[i].b1));
        end
        chk("underflow_set", 32'(a_uf), 1);
        wait_fs(200, n);
        chk("underflow_sticky", 32'(a_uf), 1);

        // Colour bars from the wider instance, first active line.
        for (int i = 0; i < 8; i++) begin
            chk("bar_b0", 32'(qb_at(2 * i)), 32'(tabp[i].b0));
            chk("bar_b1", 32'(qb_at(2 * i + 1)), 32'(tabp[i].b1));
        end
        chk("pattern_no_ready", rdy_b, 0);
        chk("pattern_no_uf", 32'(b_uf), 0);

        // Enable dropped inside the active region.
        clear_counts();
        repeat (60) cycle();
        enable = 0;
        repeat (300) cycle();
        chk("drop_href_clks", hr_cnt, 32);
        chk("drop_vsync_clks", vs_cnt, 19);
        chk("drop_no_fs", fs_cnt, 0);
        chk("drop_idle_vsync", 32'(a_vsync), 0);
        enable = 1;
        wait_fs(10, n);
        chk("restart_le2", 32'(n <= 2), 1);

        // Reset pulse in the middle of an active line.
        repeat (50) cycle();
        chk("mid_line_href", 32'(a_href), 1);
        rst = 1;
        cycle();
        rst = 0;
        chk("abort_outputs", 32'({a_pclk, a_vsync, a_href, a_data, a_ready, a_fs, a_uf}), 0);
        wait_fs(10, n);
        chk("rst_restart_le2", 32'(n <= 2), 1);

        // Randomized run against the model.
        valid_pct = 85;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            if ($urandom_range(0, 199) == 0) pattern_en = ~pattern_en;
            rst = ($urandom_range(0, 999) == 0);
            cycle();
        end
        rst = 0;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
